// File: rtl/readout_seq.sv
// readout_seq -- row-by-row pixel readout sequencer.
//
// It answers the exposure sequencer's trigger and holds re_busy high for the
// whole frame readout. For each row it selects the row, strobes the signal
// sample, the pixel reset and the reset sample, then starts the column ADC. It
// waits for the conversion and then for room downstream before it moves on.
//
// Ports:
//   CLKM        clock
//   rst         synchronous active-high reset; clears the state and every output
//   trigger_i   readout request (level), sampled only while idle
//   re_busy     readout in progress; low in IDLE and in the DONE cycle
//   NUM_ROW     rows per frame; 0 is treated as 1; latched on accept
//   T_setup     row-select settle cycles; latched on accept
//   T_sig       SH_SIG pulse width; latched on accept
//   T_res       PIXRES pulse width; latched on accept
//   T_rst       SH_RST pulse width; latched on accept
//   adc_done    conversion complete; looked at only while converting
//   fifo_full   downstream buffer full; stalls the move to the next row
//   ROWADD      selected row; holds its value between frames
//   PIXREAD_EN  row read enable, SETUP through CONV
//   SH_SIG      signal-level sample strobe
//   PIXRES      pixel reset strobe
//   SH_RST      reset-level sample strobe
//   ADC_START   one-cycle pulse on the first conversion cycle
//   row_valid   one-cycle pulse when a row's conversion completes
//   row_idx     row number that goes with row_valid
//   frame_done  one-cycle pulse at the end of the frame
//
// Every phase timer lasts max(T,1) cycles. All outputs come from registers that
// are loaded from the next state, so they line up with the registered state.

module readout_seq #(
    parameter int ROW_W = 10,
    parameter int TW    = 32
) (
    input  logic             CLKM,
    input  logic             rst,
    input  logic             trigger_i,
    output logic             re_busy,
    input  logic [ROW_W-1:0] NUM_ROW,
    input  logic [TW-1:0]    T_setup,
    input  logic [TW-1:0]    T_sig,
    input  logic [TW-1:0]    T_res,
    input  logic [TW-1:0]    T_rst,
    input  logic             adc_done,
    input  logic             fifo_full,
    output logic [ROW_W-1:0] ROWADD,
    output logic             PIXREAD_EN,
    output logic             SH_SIG,
    output logic             PIXRES,
    output logic             SH_RST,
    output logic             ADC_START,
    output logic             row_valid,
    output logic [ROW_W-1:0] row_idx,
    output logic             frame_done
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSetup = 3'd1;
    localparam logic [2:0] StSig   = 3'd2;
    localparam logic [2:0] StPres  = 3'd3;
    localparam logic [2:0] StRsmp  = 3'd4;
    localparam logic [2:0] StConv  = 3'd5;
    localparam logic [2:0] StNext  = 3'd6;
    localparam logic [2:0] StDone  = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [ROW_W-1:0] row_q, row_d;

    // Configuration captured at accept
    logic [ROW_W-1:0] nrow_q;
    logic [TW-1:0]    t_setup_q, t_sig_q, t_res_q, t_rst_q;
    logic             latch_en;

    // Next values of the registered outputs
    logic             re_busy_d, pixread_d, sh_sig_d, pixres_d, sh_rst_d;
    logic             adc_start_d, row_valid_d, frame_done_d;
    logic [ROW_W-1:0] rowadd_d, row_idx_d;

    logic [TW-1:0]    cur_t;
    logic             phase_last;
    logic [ROW_W-1:0] last_row;

    // Length of the current timed phase. T = 0 and T = 1 both finish after one cycle.
    always_comb begin
        cur_t = '0;
        unique case (state_q)
            StSetup: cur_t = t_setup_q;
            StSig:   cur_t = t_sig_q;
            StPres:  cur_t = t_res_q;
            StRsmp:  cur_t = t_rst_q;
            default: cur_t = '0;
        endcase
    end

    assign phase_last = (cur_t <= TW'(1)) || (tmr_q == cur_t - TW'(1));
    assign last_row   = (nrow_q == '0) ? '0 : nrow_q - ROW_W'(1);

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        row_d       = row_q;
        latch_en    = 1'b0;
        row_valid_d = 1'b0;
        row_idx_d   = row_idx;

        unique case (state_q)
            StIdle: begin
                if (trigger_i) begin
                    latch_en = 1'b1;
                    row_d    = '0;
                    tmr_d    = '0;
                    state_d  = StSetup;
                end
            end
            StSetup, StSig, StPres, StRsmp: begin
                if (phase_last) begin
                    tmr_d   = '0;
                    state_d = state_q + 3'd1;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            StConv: begin
                // There is no timeout: the sequencer waits for the ADC as long as it takes.
                if (adc_done) begin
                    row_valid_d = 1'b1;
                    row_idx_d   = row_q;
                    state_d     = StNext;
                end
            end
            StNext: begin
                if (!fifo_full) begin
                    if (row_q == last_row) begin
                        state_d = StDone;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        tmr_d   = '0;
                        state_d = StSetup;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // The outputs are decoded from the next state and registered with it.
    always_comb begin
        re_busy_d    = (state_d != StIdle) && (state_d != StDone);
        pixread_d    = (state_d >= StSetup) && (state_d <= StConv);
        sh_sig_d     = (state_d == StSig);
        pixres_d     = (state_d == StPres);
        sh_rst_d     = (state_d == StRsmp);
        // Only the cycle that enters CONV starts a conversion
        adc_start_d  = (state_d == StConv) && (state_q != StConv);
        frame_done_d = (state_d == StDone);
        rowadd_d     = pixread_d ? row_d : ROWADD;
    end

    always_ff @(posedge CLKM) begin
        if (rst) begin
            state_q    <= StIdle;
            tmr_q      <= '0;
            row_q      <= '0;
            nrow_q     <= '0;
            t_setup_q  <= '0;
            t_sig_q    <= '0;
            t_res_q    <= '0;
            t_rst_q    <= '0;
            re_busy    <= 1'b0;
            PIXREAD_EN <= 1'b0;
            SH_SIG     <= 1'b0;
            PIXRES     <= 1'b0;
            SH_RST     <= 1'b0;
            ADC_START  <= 1'b0;
            row_valid  <= 1'b0;
            frame_done <= 1'b0;
            ROWADD     <= '0;
            row_idx    <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            row_q      <= row_d;
            if (latch_en) begin
                nrow_q    <= NUM_ROW;
                t_setup_q <= T_setup;
                t_sig_q   <= T_sig;
                t_res_q   <= T_res;
                t_rst_q   <= T_rst;
            end
            re_busy    <= re_busy_d;
            PIXREAD_EN <= pixread_d;
            SH_SIG     <= sh_sig_d;
            PIXRES     <= pixres_d;
            SH_RST     <= sh_rst_d;
            ADC_START  <= adc_start_d;
            row_valid  <= row_valid_d;
            frame_done <= frame_done_d;
            ROWADD     <= rowadd_d;
            row_idx    <= row_idx_d;
        end
    end

endmodule

// File: tb/tb_readout_seq.sv
// tb_readout_seq -- self-checking bench for readout_seq.
//
// Each frame is described as a list of phases with known lengths. From that list
// the bench builds two things in advance: the input stimulus for every cycle and
// the output vector expected after every clock edge. The inputs are then played
// back cycle by cycle and each output vector is compared. Inputs that the design
// must ignore (the ADC outside CONV, the FIFO outside NEXT, the configuration
// outside accept) are filled with random values.

module tb_readout_seq;

    localparam int N = 8192;

    logic        CLKM = 1'b0;
    logic        rst;
    logic        trigger_i;
    logic        re_busy;
    logic [9:0]  NUM_ROW;
    logic [31:0] T_setup, T_sig, T_res, T_rst;
    logic        adc_done, fifo_full;
    logic [9:0]  ROWADD;
    logic        PIXREAD_EN, SH_SIG, PIXRES, SH_RST, ADC_START, row_valid, frame_done;
    logic [9:0]  row_idx;

    readout_seq #(.ROW_W(10), .TW(32)) dut (
        .CLKM       (CLKM),
        .rst        (rst),
        .trigger_i  (trigger_i),
        .re_busy    (re_busy),
        .NUM_ROW    (NUM_ROW),
        .T_setup    (T_setup),
        .T_sig      (T_sig),
        .T_res      (T_res),
        .T_rst      (T_rst),
        .adc_done   (adc_done),
        .fifo_full  (fifo_full),
        .ROWADD     (ROWADD),
        .PIXREAD_EN (PIXREAD_EN),
        .SH_SIG     (SH_SIG),
        .PIXRES     (PIXRES),
        .SH_RST     (SH_RST),
        .ADC_START  (ADC_START),
        .row_valid  (row_valid),
        .row_idx    (row_idx),
        .frame_done (frame_done)
    );

    always #5 CLKM = ~CLKM;

    // Stimulus for cycle i is sampled at clock edge i. e_out[i] is the output expected after that edge.
    bit          s_trig [N];
    bit          s_adc  [N];
    bit          s_fifo [N];
    bit          s_rst  [N];
    logic [9:0]  s_nrow [N];
    logic [31:0] s_ts   [N];
    logic [31:0] s_tg   [N];
    logic [31:0] s_tp   [N];
    logic [31:0] s_tr   [N];
    logic [27:0] e_out  [N];

    int          n;
    int          n_cmp;
    int          n_bad;
    int          n_fd_exp;
    int          n_fd_obs;
    logic [9:0]  m_rowadd;
    logic [9:0]  m_rowidx;
    logic [27:0] obs;

    assign obs = {re_busy, PIXREAD_EN, SH_SIG, PIXRES, SH_RST, ADC_START, row_valid, frame_done,
                  ROWADD, row_idx};

    function automatic int dur(input int t);
        return (t == 0) ? 1 : t;
    endfunction

    task automatic put(input bit busy, input bit pix, input bit sig, input bit pres,
                       input bit shr, input bit start, input bit rv, input bit fd);
        e_out[n] = {busy, pix, sig, pres, shr, start, rv, fd, m_rowadd, m_rowidx};
        n++;
    endtask

    task automatic idle(input int k);
        repeat (k) put(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One frame: accept, then for each row SETUP, SIG, PRES, RSMP, CONV (ADC answers after d
    // extra cycles), NEXT (stalled by fifo_full), then DONE. When abort_row >= 0 the frame is
    // cut by a reset on the second CONV cycle of that row.
    task automatic frame(input int nr, input int ts, input int tg, input int tp, input int tr,
                         input int dmin, input int dmax, input int stall0, input int smax,
                         input int hold, input bit tie, input int abort_row);
        int a;
        int rows;
        int d;
        int st;
        a         = n;
        s_trig[a] = 1'b1;
        s_nrow[a] = 10'(nr);
        s_ts[a]   = 32'(ts);
        s_tg[a]   = 32'(tg);
        s_tp[a]   = 32'(tp);
        s_tr[a]   = 32'(tr);
        // The initiator keeps trigger_i high for a few cycles after accept; it must be ignored
        for (int h = 1; h <= hold; h++) s_trig[a + h] = 1'b1;
        rows = (nr == 0) ? 1 : nr;
        for (int r = 0; r < rows; r++) begin
            m_rowadd = 10'(r);
            repeat (dur(ts)) put(1, 1, 0, 0, 0, 0, 0, 0);
            repeat (dur(tg)) begin
                s_adc[n + 1] = 1'b1;  // stray ADC pulse during SIG
                put(1, 1, 1, 0, 0, 0, 0, 0);
            end
            repeat (dur(tp)) put(1, 1, 0, 1, 0, 0, 0, 0);
            repeat (dur(tr)) put(1, 1, 0, 0, 1, 0, 0, 0);
            d = tie ? 0 : int'($urandom_range(dmax, dmin));
            for (int k = 0; k <= d; k++) begin
                s_adc[n + 1] = (k == d);
                put(1, 1, 0, 0, 0, k == 0, 0, 0);
                if (r == abort_row && k == 1) begin
                    s_rst[n] = 1'b1;
                    m_rowadd = '0;
                    m_rowidx = '0;
                    put(0, 0, 0, 0, 0, 0, 0, 0);
                    return;
                end
            end
            m_rowidx = 10'(r);
            st = (r == 0) ? stall0 : int'($urandom_range(smax, 0));
            for (int j = 0; j <= st; j++) begin
                s_fifo[n + 1] = (j < st);
                put(1, 0, 0, 0, 0, 0, j == 0, 0);
            end
        end
        put(0, 0, 0, 0, 0, 0, 0, 1);
        if (tie) for (int i = a; i < n; i++) s_adc[i] = 1'b1;
    endtask

    initial begin
        n        = 0;
        n_cmp    = 0;
        n_bad    = 0;
        n_fd_exp = 0;
        n_fd_obs = 0;
        for (int i = 0; i < N; i++) begin
            s_trig[i] = 1'b0;
            s_rst[i]  = 1'b0;
            s_adc[i]  = ($urandom_range(3, 0) == 0);
            s_fifo[i] = $urandom_range(1, 0) != 0;
            s_nrow[i] = 10'($urandom);
            s_ts[i]   = $urandom;
            s_tg[i]   = $urandom;
            s_tp[i]   = $urandom;
            s_tr[i]   = $urandom;
        end

        // Reset state
        s_rst[0] = 1'b1;
        m_rowadd = '0;
        m_rowidx = '0;
        put(0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // Basic frame: 3 rows, all timings 2, ADC answers one cycle after start
        frame(3, 2, 2, 2, 2, 1, 1, 0, 0, 1, 1'b0, -1);
        idle(2);
        // Zero timings with adc_done tied high, then NUM_ROW = 0
        frame(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, -1);
        idle(1);
        frame(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, -1);
        idle(2);
        // Backpressure: NEXT of row 0 stalls 10 cycles
        frame(3, 1, 1, 1, 1, 0, 2, 10, 0, 0, 1'b0, -1);
        idle(3);
        // Handshake: two back-to-back frames, config changed mid-frame (3 then 5)
        frame(3, 1, 2, 0, 3, 0, 3, 1, 2, 2, 1'b0, -1);
        idle(1);
        frame(5, 0, 1, 2, 1, 0, 3, 0, 2, 2, 1'b0, -1);
        idle(2);
        // Reset during CONV of row 1, then a restart from row 0
        frame(4, 1, 1, 1, 1, 5, 5, 0, 0, 0, 1'b0, 1);
        idle(2);
        frame(2, 1, 1, 1, 1, 0, 1, 0, 0, 1, 1'b0, -1);
        idle(2);
        // ADC stall of 50 cycles with stray adc_done during SIG
        frame(1, 2, 3, 2, 2, 50, 50, 0, 0, 0, 1'b0, -1);
        idle(2);
        // Randomized frames
        for (int f = 0; f < 10; f++) begin
            frame(int'($urandom_range(6, 0)), int'($urandom_range(5, 0)),
                  int'($urandom_range(5, 0)), int'($urandom_range(5, 0)),
                  int'($urandom_range(5, 0)), 0, 4, int'($urandom_range(3, 0)), 3,
                  int'($urandom_range(2, 0)), 1'b0, -1);
            idle(int'($urandom_range(3, 1)));
        end

        for (int i = 0; i < n; i++) if (e_out[i][20]) n_fd_exp++;

        for (int i = 0; i < n; i++) begin
            @(negedge CLKM);
            rst       = s_rst[i];
            trigger_i = s_trig[i];
            adc_done  = s_adc[i];
            fifo_full = s_fifo[i];
            NUM_ROW   = s_nrow[i];
            T_setup   = s_ts[i];
            T_sig     = s_tg[i];
            T_res     = s_tp[i];
            T_rst     = s_tr[i];
            @(posedge CLKM);
            #1;
            n_cmp++;
            if (frame_done === 1'b1) n_fd_obs++;
            assert (obs === e_out[i]) else begin
                n_bad++;
                $error("FAIL cyc%0d {busy,pix,sig,pres,shr,start,rv,fd,row,idx}: observed %h required %h",
                       i, obs, e_out[i]);
            end
            if (s_rst[i]) begin
                n_cmp++;
                if (obs !== 28'h0) begin
                    n_bad++;
                    $error("FAIL cyc%0d reset state: outputs %h not all zero", i, obs);
                end
            end
        end

        n_cmp++;
        if (n_fd_obs != n_fd_exp || n_cmp < n) begin
            n_bad++;
            $error("FAIL wait expired: frame_done seen %0d times, required %0d", n_fd_obs,
                   n_fd_exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
